// File: rtl/mem_bus_responder.sv
// mem_bus_responder: single-port word memory target for the CPU bus (addr/data/cs/we/oe) with a rdy handshake.
// Latency: access commits WAIT_STATES edges after the request edge; rdy pulses the cycle after; one access per WAIT_STATES+2 cycles.
// Backpressure: requests are sampled only in IDLE; cs held during WAIT/DONE is ignored. Optional MEM_WRITE_PROTECT_EN guards low addresses.
module mem_bus_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 0,
    parameter int PROT_LIMIT  = 'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    output logic                  rdy,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Counter is loaded with WAIT_STATES-1 so the commit lands exactly WAIT_STATES edges after the request edge.
    localparam logic [3:0] WS_M1     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif
    localparam logic [ADDR_WIDTH-1:0] PROT_A = ADDR_WIDTH'(PROT_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic                    rd_valid_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    commit;
    logic                    cnt_load;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic                    c_we;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic                    wr_blocked;

    // With zero wait states the commit happens on the accept edge, so it must use the live bus rather than the latches.
    assign c_addr  = (state_q == IDLE) ? addr : addr_q;
    assign c_we    = (state_q == IDLE) ? we   : we_q;
    assign c_wdata = (state_q == IDLE) ? data : wdata_q;

    assign wr_blocked = PROT_EN && (c_addr < PROT_A);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        commit   = 1'b0;
        cnt_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs) begin
                    accept = 1'b1;
                    if (ZERO_WAIT) begin
                        commit  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latches, wait counter, read data register and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= addr;
                we_q       <= we;
                rd_valid_q <= 1'b0;
                if (we) begin
                    wdata_q <= data;
                end
                // we and oe together is a protocol violation; it still completes as a write.
                if (we && oe) begin
                    err_q <= 1'b1;
                end
            end
            if (cnt_load) begin
                cnt_q <= WS_M1;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Commit after the accept block so a zero-wait read sets rd_valid on the same edge that cleared it.
            if (commit) begin
                if (!c_we) begin
                    rd_q       <= mem[c_addr];
                    rd_valid_q <= 1'b1;
                end else if (wr_blocked) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Storage array; contents survive reset, and a write only happens at commit.
    always_ff @(posedge clk) begin
        if (commit && c_we && !wr_blocked) begin
            mem[c_addr] <= c_wdata;
        end
    end

    assign rdy  = (state_q == DONE);
    assign err  = err_q;
    // Only drive the shared bus for a read the initiator is currently enabling.
    assign data = (rd_valid_q && cs && oe && !we) ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of three responder instances (0, 2 and 3 wait states).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mem_bus_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic       we;
    logic       oe;
    logic       drv_en;
    logic [7:0] drv_val;
    logic       cs_on;
    int         sel;

    logic cs0, cs2, cs3;
    logic rdy0, rdy2, rdy3;
    logic err0, err2, err3;
    wire [7:0] data0;
    wire [7:0] data2;
    wire [7:0] data3;

    int checks;
    int failures;

    assign cs0 = cs_on && (sel == 0);
    assign cs2 = cs_on && (sel == 2);
    assign cs3 = cs_on && (sel == 3);

    assign data0 = drv_en ? drv_val : 8'hzz;
    assign data2 = drv_en ? drv_val : 8'hzz;
    assign data3 = drv_en ? drv_val : 8'hzz;

    // Undriven buses float to all-ones so high-Z is observable.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu0 (data0[i]);
        pullup pu2 (data2[i]);
        pullup pu3 (data3[i]);
    end

    mem_bus_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0), .PROT_LIMIT('h20)) u0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data0),
        .cs(cs0), .we(we), .oe(oe), .rdy(rdy0), .err(err0)
    );
    mem_bus_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(2), .PROT_LIMIT('h20)) u2 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data2),
        .cs(cs2), .we(we), .oe(oe), .rdy(rdy2), .err(err2)
    );
    mem_bus_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(3), .PROT_LIMIT('h20)) u3 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data3),
        .cs(cs3), .we(we), .oe(oe), .rdy(rdy3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cs;
        logic       we;
        logic       oe;
        logic       drv;
        logic [7:0] a;
        logic [7:0] d;
        logic       exp_rdy;
        logic       chk_bus;
        logic [7:0] exp_bus;
        logic       exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic c, input logic w, input logic o, input logic dv,
                                input logic [7:0] a, input logic [7:0] d, input logic r,
                                input logic cb, input logic [7:0] b, input logic e);
        vec_t v;
        v.cs = c; v.we = w; v.oe = o; v.drv = dv; v.a = a; v.d = d;
        v.exp_rdy = r; v.chk_bus = cb; v.exp_bus = b; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic cur_rdy(input int s);
        case (s)
            0:       return rdy0;
            2:       return rdy2;
            default: return rdy3;
        endcase
    endfunction

    function automatic logic [7:0] cur_bus(input int s);
        case (s)
            0:       return data0;
            2:       return data2;
            default: return data3;
        endcase
    endfunction

    // One full access: hold the request until rdy (bounded), capture the bus in the rdy cycle, then release.
    task automatic access(input int s, input logic w, input logic o, input logic [7:0] a,
                          input logic [7:0] d, output logic ok, output logic [7:0] rd);
        sel = s; cs_on = 1'b1; we = w; oe = o; addr = a; drv_val = d; drv_en = w;
        ok = 1'b0;
        rd = 8'h00;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (cur_rdy(s)) begin
                ok = 1'b1;
                rd = cur_bus(s);
            end
        end
        cs_on = 1'b0; we = 1'b0; oe = 1'b0; drv_en = 1'b0;
        tick();
    endtask

    initial begin
        logic       ok;
        logic [7:0] rd;
        int         pulses;

        checks = 0; failures = 0;
        rst_n = 1'b0; addr = 8'h00; we = 1'b0; oe = 1'b0;
        drv_en = 1'b0; drv_val = 8'h00; cs_on = 1'b0; sel = 0;

        repeat (3) @(negedge clk);
        check("reset_rdy0", {7'd0, rdy0}, 8'd0);
        check("reset_err0", {7'd0, err0}, 8'd0);
        check("reset_bus0", data0, 8'hFF);
        check("reset_rdy2", {7'd0, rdy2}, 8'd0);
        check("reset_rdy3", {7'd0, rdy3}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait instance: per-cycle vectors (cs, we, oe, drv, addr, wdata, rdy, chk_bus, bus, err).
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h00, 8'h10, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 1, 1, 8'h10, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h10, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 1, 1, 8'h10, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h20, 8'h0B, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h21, 8'h01, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h21, 8'h01, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h20, 8'h00, 1, 1, 8'h0B, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h21, 8'h00, 0, 1, 8'h0B, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h21, 8'h00, 1, 1, 8'h01, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h20, 8'h00, 0, 1, 8'h01, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h20, 8'h00, 1, 1, 8'h0B, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h10, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 1, 1, 1, 8'h30, 8'h55, 1, 0, 8'h00, 1));
        tbl.push_back(mk(1, 1, 1, 0, 8'h30, 8'h00, 0, 1, 8'hFF, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 1));
        tbl.push_back(mk(1, 0, 1, 0, 8'h30, 8'h00, 1, 1, 8'h55, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 1));

        sel = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            cs_on = tbl[i].cs; we = tbl[i].we; oe = tbl[i].oe;
            drv_en = tbl[i].drv; addr = tbl[i].a; drv_val = tbl[i].d;
            tick();
            check($sformatf("vec%0d_rdy", i), {7'd0, rdy0}, {7'd0, tbl[i].exp_rdy});
            check($sformatf("vec%0d_err", i), {7'd0, err0}, {7'd0, tbl[i].exp_err});
            if (tbl[i].chk_bus) begin
                check($sformatf("vec%0d_bus", i), data0, tbl[i].exp_bus);
            end
        end
        cs_on = 1'b0; we = 1'b0; oe = 1'b0; drv_en = 1'b0;
        tick();

        // Two wait states: write 1D<-01 while scrambling the inputs during WAIT; the latched request must win.
        sel = 2; cs_on = 1'b1; we = 1'b1; oe = 1'b0; addr = 8'h1D; drv_en = 1'b1; drv_val = 8'h01;
        tick();
        check("ws2_wr_rdy_e0", {7'd0, rdy2}, 8'd0);
        addr = 8'h00; drv_val = 8'hEE;
        tick();
        check("ws2_wr_rdy_e1", {7'd0, rdy2}, 8'd0);
        tick();
        check("ws2_wr_rdy_e2", {7'd0, rdy2}, 8'd1);
        cs_on = 1'b0; we = 1'b0; drv_en = 1'b0;
        tick();
        check("ws2_wr_rdy_e3", {7'd0, rdy2}, 8'd0);

        // Two wait states: read 1D; bus floats until commit, then holds 01 while cs/oe stay high.
        cs_on = 1'b1; we = 1'b0; oe = 1'b1; addr = 8'h1D;
        tick();
        check("ws2_rd_rdy_e0", {7'd0, rdy2}, 8'd0);
        check("ws2_rd_bus_e0", data2, 8'hFF);
        tick();
        check("ws2_rd_rdy_e1", {7'd0, rdy2}, 8'd0);
        check("ws2_rd_bus_e1", data2, 8'hFF);
        tick();
        check("ws2_rd_rdy_e2", {7'd0, rdy2}, 8'd1);
        check("ws2_rd_bus_e2", data2, 8'h01);
        tick();
        check("ws2_rd_rdy_e3", {7'd0, rdy2}, 8'd0);
        check("ws2_rd_bus_e3", data2, 8'h01);
        cs_on = 1'b0; oe = 1'b0;
        tick();
        check("ws2_err", {7'd0, err2}, 8'd0);

        // Three wait states: establish 05=3C, then abort a write of AA with reset in the second WAIT cycle.
        access(3, 1'b1, 1'b0, 8'h05, 8'h3C, ok, rd);
        check("ws3_pre_rdy", {7'd0, ok}, 8'd1);
        sel = 3; cs_on = 1'b1; we = 1'b1; oe = 1'b0; addr = 8'h05; drv_en = 1'b1; drv_val = 8'hAA;
        tick();
        cs_on = 1'b0; we = 1'b0; drv_en = 1'b0;
        pulses = rdy3 ? 1 : 0;
        tick();
        if (rdy3) pulses++;
        check("err0_sticky_before_reset", {7'd0, err0}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("ws3_err_in_reset", {7'd0, err3}, 8'd0);
        check("err0_cleared_by_reset", {7'd0, err0}, 8'd0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rdy3) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rdy3) pulses++;
        end
        check("ws3_abort_rdy_pulses", 8'(pulses), 8'd0);
        check("ws3_abort_err", {7'd0, err3}, 8'd0);
        access(3, 1'b0, 1'b1, 8'h05, 8'h00, ok, rd);
        check("ws3_rd_rdy", {7'd0, ok}, 8'd1);
        check("ws3_rd_prior_value", rd, 8'h3C);

        // Write protection boundary on the zero-wait instance.
        access(0, 1'b1, 1'b0, 8'h1C, 8'h77, ok, rd);
        check("prot_wr1c_rdy", {7'd0, ok}, 8'd1);
        access(0, 1'b0, 1'b1, 8'h1C, 8'h00, ok, rd);
        check("prot_rd1c_rdy", {7'd0, ok}, 8'd1);
`ifdef MEM_WRITE_PROTECT_EN
        check("prot_wr1c_err", {7'd0, err0}, 8'd1);
        checks++;
        if (rd === 8'h77) begin
            failures++;
            $display("FAIL prot_rd1c_unchanged: got %h expected anything but 77", rd);
        end
`else
        check("prot_wr1c_err", {7'd0, err0}, 8'd0);
        check("prot_rd1c_value", rd, 8'h77);
`endif
        access(0, 1'b1, 1'b0, 8'h20, 8'h77, ok, rd);
        check("prot_wr20_rdy", {7'd0, ok}, 8'd1);
        access(0, 1'b0, 1'b1, 8'h20, 8'h00, ok, rd);
        check("prot_rd20_value", rd, 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side target for the accumulator CPU's single-port memory bus (addr, data, cs, we, oe).
- Holds 2**ADDR_WIDTH words of DATA_WIDTH bits.
- Accepts one access at a time, inserts a programmable number of wait states, and signals completion on rdy.
- Drives the shared bidirectional data bus only during read data phases, so the CPU core can move from fixed-delay fetch/execute to a rdy handshake.

Parameters:
ADDR_WIDTH, 8, address bits; storage depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, word width
WAIT_STATES, 0, extra cycles between request sample and access commit (0..15)
PROT_LIMIT, 'h20, first writable address when MEM_WRITE_PROTECT_EN is defined

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
addr  input  ADDR_WIDTH  word address from MAR
data  inout  DATA_WIDTH  shared data bus; write data in, read data out
cs  input  1  chip select; request valid when high
we  input  1  write enable
oe  input  1  output enable; responder may drive data only while high
rdy  output  1  one-cycle pulse: access committed
err  output  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0, rdy=0, err=0, rd_valid=0, data bus high-Z.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Each rising edge with cs=1 accepts a request: latch addr, we, oe and, if we=1, the data bus value.
  - rd_valid cleared on accept.
  - WAIT_STATES=0: commit at this same edge, go to DONE.
  - WAIT_STATES>0: counter loaded with WAIT_STATES-1, go to WAIT.
  - cs=0: stay IDLE.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0: commit the access, go to DONE.
  - cs/we/oe/addr changes during WAIT are ignored; the latched request always completes.
- Commit:
  - Latched we=1: mem[addr_q] <= wdata_q.
  - Else: rd_q <= mem[addr_q], rd_valid <= 1.
- DONE:
  - rdy=1 for exactly one cycle; next edge unconditionally returns to IDLE.
  - A request is not sampled in DONE.
  - Back-to-back throughput: one access per WAIT_STATES+2 cycles.
- Latency: rdy high in the cycle after edge (request edge + WAIT_STATES). Write data is visible to a read issued in any later request.
- Bus drive:
  - data = rd_q when rd_valid=1 and cs=1 and oe=1 and we=0; otherwise high-Z.
  - rd_q persists until the next request is accepted, so it can be read on multiple cycles.
- Conflicting request (we=1 and oe=1 at accept): treated as a write; err set to 1.
- err is sticky and cleared only by reset.
- Reset mid-access: pending write is discarded, memory unchanged, FSM back to IDLE.
- Address is exactly ADDR_WIDTH bits; no aliasing or out-of-range case.

Optional Feature:
- Macro: MEM_WRITE_PROTECT_EN.
- Defined:
  - A committed write with addr_q < PROT_LIMIT does not modify memory and sets err.
  - rdy still pulses normally so the initiator never hangs.
  - Reads are unaffected.
- Undefined: all addresses writable; PROT_LIMIT unused.

Test Plan:
- WAIT_STATES=0: write 'h10 to 'h00, then read 'h00 with oe=1 -> rdy pulses 1 cycle after each request edge; data='h10 while cs=1, oe=1; err=0.
- WAIT_STATES=2: read 'h1D preloaded 'h01 -> rdy high exactly 3 cycles after the request edge and for 1 cycle only; data high-Z before commit, 'h01 after commit.
- Hold cs=1 continuously with alternating addresses 'h20/'h21 (WAIT_STATES=0) -> one access per 2 cycles; DONE never samples a request; values 'h0B and 'h01 returned in order.
- Write 'hAA to 'h05 with WAIT_STATES=3; pull rst_n low in the second WAIT cycle -> rdy never pulses, err=0, subsequent read of 'h05 returns the prior value.
- Request with we=1, oe=1, data='h55 to 'h30 -> mem['h30]='h55; err=1 and stays 1 until reset; bus never driven by the responder during this request.
- MEM_WRITE_PROTECT_EN, PROT_LIMIT='h20: write 'h77 to 'h1C -> rdy pulses, mem['h1C] unchanged, err=1. Write 'h77 to 'h20 -> stored.
